cms_ctrl_arbiter: RTL and testbench
===================================

CMS_CTRL_ARBITER -- requirements
Module: cms_ctrl_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, the control address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the control write-data width.
REQ-003 SHALL have parameter RECOVER_CYCLES, default 1, range 1..15: number of write-enable-low cycles after each strobe.
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports req0_valid/req1_valid, input, 1 each, requester write pending; req0 is the host and req1 is the trigger unit.
REQ-007 SHALL have ports req0_addr/req1_addr, input, ADDR_WIDTH each, and req0_wdata/req1_wdata, input, DATA_WIDTH each.
REQ-008 SHALL have ports req0_ready/req1_ready, output, 1 each, the accept strobe.
REQ-009 SHALL have ports ctrl_addr (output, ADDR_WIDTH), ctrl_wdata (output, DATA_WIDTH) and ctrl_write_enable (output, 1), which drive the monitoring-system control port.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 SHALL implement the FSM IDLE -> SETUP -> STROBE -> RECOVER -> IDLE.
REQ-012 IDLE SHALL, when any req valid, assert exactly one reqN_ready combinationally; a handshake (valid&ready) SHALL latch addr/wdata/grant id and go to SETUP next cycle.
REQ-013 Arbitration SHALL be round-robin: single valid wins; both valid -> requester not granted last wins; last_grant resets to 1, so req0 wins the first tie.
REQ-014 SETUP (1 cycle) SHALL drive latched ctrl_addr/ctrl_wdata with ctrl_write_enable=0.
REQ-015 STROBE (1 cycle) SHALL hold addr/data and drive ctrl_write_enable=1, giving one rising edge per write.
REQ-016 RECOVER SHALL hold addr/data, drive ctrl_write_enable=0 for exactly RECOVER_CYCLES cycles using a 4-bit down-counter, then return to IDLE.
REQ-017 Latency: handshake in cycle N -> write_enable high in cycle N+2 only; next ready earliest in cycle N+3+RECOVER_CYCLES.
REQ-018 reqN_ready SHALL be 0 outside IDLE; requests valid during a transfer SHALL wait and not be dropped or merged.
REQ-019 A requester dropping valid before its handshake SHALL cause no write.
REQ-020 ctrl_addr/ctrl_wdata SHALL retain the last written values in IDLE, so they change only in SETUP.

Reset
REQ-021 rst_n low SHALL immediately force state=IDLE, ctrl_addr=0, ctrl_wdata=0, ctrl_write_enable=0, busy=0, last_grant=1, recover counter=0, and all statistics counters to 0.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer without completing the strobe; the requester SHALL re-issue the write after reset.

Configuration
REQ-023 Macro CMS_CTRL_ARB_STATS_EN defined SHALL add outputs grant_count0/grant_count1, 32 bits each, incremented on each handshake of that requester and wrapping 0xFFFFFFFF -> 0.
REQ-024 With CMS_CTRL_ARB_STATS_EN undefined, those ports and counters SHALL not exist; all other behaviour SHALL be identical.

Structure
REQ-025 A shared package SHALL hold the FSM state encoding (2 bits: IDLE=0, SETUP=1, STROBE=2, RECOVER=3) and the default ADDR_WIDTH/DATA_WIDTH constants, for reuse by the monitoring-system bench.
REQ-026 The block SHALL be flat with no sub-modules; the round-robin grant logic SHALL be an internal combinational section.

Verification
REQ-027 Single write test: req0 addr=0x05, wdata=0x1234 -> exactly one ctrl_write_enable pulse 2 cycles after the handshake with ctrl_addr=0x05, ctrl_wdata=0x1234; busy high for 3 cycles (RECOVER_CYCLES=1).
REQ-028 Tie test: req0 and req1 valid continuously -> grants in order req0, req1, req0, req1, with write_enable edges 4 cycles apart.
REQ-029 Back-pressure test: req1 raised during req0's STROBE -> req1_ready low until IDLE, then req1 is written with its own addr/data.
REQ-030 Reset-abort test: rst_n pulsed low in SETUP -> no write_enable pulse, all outputs 0, and the next req0 write after reset proceeds normally.
REQ-031 Recovery test: RECOVER_CYCLES=3 -> write_enable low for exactly 3 cycles between back-to-back writes.
REQ-032 Statistics test: with CMS_CTRL_ARB_STATS_EN and grant_count0 preset via force to 0xFFFFFFFF, one req0 write -> grant_count0 = 0 and grant_count1 unchanged.

Source files
------------

// File: rtl/cms_ctrl_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cms_ctrl_arbiter_pkg
// Shared definitions for the monitoring-system control-port arbiter. The bench
// that drives the complete monitoring system reuses these definitions.
//   - arb_state_e            : 2-bit FSM encoding (IDLE=0, SETUP=1, STROBE=2, RECOVER=3)
//   - CMS_DEFAULT_ADDR_WIDTH : default control address width
//   - CMS_DEFAULT_DATA_WIDTH : default control write-data width
//   - rr_pick()              : round-robin winner (0 = host, 1 = trigger unit)
// -----------------------------------------------------------------------------
package cms_ctrl_arbiter_pkg;

    localparam int CMS_DEFAULT_ADDR_WIDTH = 8;
    localparam int CMS_DEFAULT_DATA_WIDTH = 64;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETUP   = 2'd1,
        ST_STROBE  = 2'd2,
        ST_RECOVER = 2'd3
    } arb_state_e;

    // A lone requester always wins. When both are requesting, the one that
    // was not granted last time wins.
    function automatic logic rr_pick(input logic v0, input logic v1, input logic last_grant);
        if (v0 && v1) begin
            return !last_grant;
        end
        return v1;
    endfunction

endpackage

// File: rtl/cms_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// cms_ctrl_arbiter
// Arbitrates control-register writes from the host (req0) and the trigger
// unit (req1) onto the single monitoring-system control port. Each write runs
// through the sequence IDLE -> SETUP -> STROBE -> RECOVER -> IDLE. This
// sequence gives exactly one write-enable pulse per write. Address and data
// stay stable around that pulse.
//
// Parameters
//   ADDR_WIDTH     : control address width
//   DATA_WIDTH     : control write-data width
//   RECOVER_CYCLES : write-enable-low cycles after each strobe (1..15)
//
// Ports
//   clk, rst_n               : clock (rising edge) and async active-low reset
//   reqN_valid/addr/wdata    : write request from requester N (0 host, 1 trigger)
//   reqN_ready               : accept strobe, only ever asserted in IDLE
//   ctrl_addr/wdata          : latched address/data of the current or last write
//   ctrl_write_enable        : high for the single STROBE cycle
//   busy                     : high whenever the FSM is not in IDLE
//   grant_count0/1           : per-requester handshake counters (only when
//                              CMS_CTRL_ARB_STATS_EN is defined)
//
// Build option: define CMS_CTRL_ARB_STATS_EN to add the 32-bit grant counters.
// -----------------------------------------------------------------------------
module cms_ctrl_arbiter
    import cms_ctrl_arbiter_pkg::*;
#(
    parameter int ADDR_WIDTH     = CMS_DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH     = CMS_DEFAULT_DATA_WIDTH,
    parameter int RECOVER_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic [ADDR_WIDTH-1:0] ctrl_addr,
    output logic [DATA_WIDTH-1:0] ctrl_wdata,
    output logic                  ctrl_write_enable,
    output logic                  busy
`ifdef CMS_CTRL_ARB_STATS_EN
    ,
    output logic [31:0]           grant_count0,
    output logic [31:0]           grant_count1
`endif
);

    // The counter is loaded when the FSM leaves STROBE. RECOVER ends on the
    // cycle in which the counter reads zero, so the load value is one less
    // than the number of recovery cycles.
    localparam logic [3:0] RECOVER_LOAD = 4'(RECOVER_CYCLES - 1);

    arb_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  last_grant_q, last_grant_d;
    logic [3:0]            rcnt_q, rcnt_d;
    logic                  grant_sel;
`ifdef CMS_CTRL_ARB_STATS_EN
    logic [31:0]           grant_count0_q, grant_count0_d;
    logic [31:0]           grant_count1_q, grant_count1_d;
`endif

    // Round-robin grant. This value only matters in IDLE while a request is pending.
    assign grant_sel = rr_pick(req0_valid, req1_valid, last_grant_q);

    always_comb begin
        state_d           = state_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        last_grant_d      = last_grant_q;
        rcnt_d            = rcnt_q;
        req0_ready        = 1'b0;
        req1_ready        = 1'b0;
        ctrl_write_enable = 1'b0;
`ifdef CMS_CTRL_ARB_STATS_EN
        grant_count0_d    = grant_count0_q;
        grant_count1_d    = grant_count1_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                // The winning requester's ready is raised only while its own
                // valid is high. Any pending request therefore completes a
                // handshake in this cycle.
                if (req0_valid || req1_valid) begin
                    req0_ready   = !grant_sel;
                    req1_ready   = grant_sel;
                    last_grant_d = grant_sel;
                    addr_d       = grant_sel ? req1_addr  : req0_addr;
                    wdata_d      = grant_sel ? req1_wdata : req0_wdata;
                    state_d      = ST_SETUP;
`ifdef CMS_CTRL_ARB_STATS_EN
                    if (grant_sel) begin
                        grant_count1_d = grant_count1_q + 32'd1;
                    end else begin
                        grant_count0_d = grant_count0_q + 32'd1;
                    end
`endif
                end
            end
            ST_SETUP: begin
                state_d = ST_STROBE;
            end
            ST_STROBE: begin
                ctrl_write_enable = 1'b1;
                rcnt_d            = RECOVER_LOAD;
                state_d           = ST_RECOVER;
            end
            ST_RECOVER: begin
                if (rcnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    rcnt_d = rcnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            wdata_q        <= '0;
            last_grant_q   <= 1'b1;
            rcnt_q         <= 4'd0;
`ifdef CMS_CTRL_ARB_STATS_EN
            grant_count0_q <= 32'd0;
            grant_count1_q <= 32'd0;
`endif
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            last_grant_q   <= last_grant_d;
            rcnt_q         <= rcnt_d;
`ifdef CMS_CTRL_ARB_STATS_EN
            grant_count0_q <= grant_count0_d;
            grant_count1_q <= grant_count1_d;
`endif
        end
    end

    assign ctrl_addr  = addr_q;
    assign ctrl_wdata = wdata_q;
    assign busy       = (state_q != ST_IDLE);
`ifdef CMS_CTRL_ARB_STATS_EN
    assign grant_count0 = grant_count0_q;
    assign grant_count1 = grant_count1_q;
`endif

endmodule

// File: tb/tb_cms_ctrl_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cms_ctrl_arbiter
// Directed bench for cms_ctrl_arbiter.
//   - dut   : default parameters (RECOVER_CYCLES = 1), driven from a vector table
//             plus a hand-written reset-abort sequence
//   - dut_b : RECOVER_CYCLES = 3, used for back-to-back recovery timing
// The grant-counter wrap check is built only when CMS_CTRL_ARB_STATS_EN is defined.
// -----------------------------------------------------------------------------
module tb_cms_ctrl_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, req0_ready, req1_ready;
    logic [7:0]  req0_addr, req1_addr, ctrl_addr;
    logic [63:0] req0_wdata, req1_wdata, ctrl_wdata;
    logic        ctrl_write_enable, busy;

    logic        b_rst_n;
    logic        b_v0, b_v1, b_r0, b_r1, b_we, b_busy;
    logic [7:0]  b_a0, b_a1, b_addr;
    logic [63:0] b_d0, b_d1, b_data;

`ifdef CMS_CTRL_ARB_STATS_EN
    logic [31:0] gc0, gc1, b_gc0, b_gc1;
`endif

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    cms_ctrl_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_wdata(req0_wdata), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_wdata(req1_wdata), .req1_ready(req1_ready),
        .ctrl_addr(ctrl_addr), .ctrl_wdata(ctrl_wdata), .ctrl_write_enable(ctrl_write_enable), .busy(busy)
`ifdef CMS_CTRL_ARB_STATS_EN
        , .grant_count0(gc0), .grant_count1(gc1)
`endif
    );

    cms_ctrl_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(64), .RECOVER_CYCLES(3)) dut_b (
        .clk(clk), .rst_n(b_rst_n),
        .req0_valid(b_v0), .req0_addr(b_a0), .req0_wdata(b_d0), .req0_ready(b_r0),
        .req1_valid(b_v1), .req1_addr(b_a1), .req1_wdata(b_d1), .req1_ready(b_r1),
        .ctrl_addr(b_addr), .ctrl_wdata(b_data), .ctrl_write_enable(b_we), .busy(b_busy)
`ifdef CMS_CTRL_ARB_STATS_EN
        , .grant_count0(b_gc0), .grant_count1(b_gc1)
`endif
    );

    typedef struct {
        logic        rst_n, v0, v1;
        logic [7:0]  a0, a1;
        logic [63:0] d0, d1;
        logic        e_r0, e_r1, e_we, e_busy;
        logic [7:0]  e_addr;
        logic [63:0] e_data;
    } vec_t;

    localparam logic [63:0] DZ = 64'h0;
    localparam logic [63:0] D1 = 64'h1234;
    localparam logic [63:0] DA = 64'hAAAA_0000_0000_AAAA;
    localparam logic [63:0] DB = 64'hBBBB_0000_0000_BBBB;
    localparam logic [63:0] DC = 64'hCCCC_CCCC_0000_0001;
    localparam logic [63:0] DD = 64'hDDDD_DDDD_0000_0002;
    localparam logic [63:0] DE = 64'hEEEE_0000_1111_0003;
    localparam logic [63:0] DF = 64'hFFFF_0000_2222_0004;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input vec_t v);
        rst_n      = v.rst_n;
        req0_valid = v.v0;
        req1_valid = v.v1;
        req0_addr  = v.a0;
        req1_addr  = v.a1;
        req0_wdata = v.d0;
        req1_wdata = v.d1;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("vec%0d.req0_ready", idx), 64'(req0_ready), 64'(v.e_r0));
        check($sformatf("vec%0d.req1_ready", idx), 64'(req1_ready), 64'(v.e_r1));
        check($sformatf("vec%0d.write_enable", idx), 64'(ctrl_write_enable), 64'(v.e_we));
        check($sformatf("vec%0d.busy", idx), 64'(busy), 64'(v.e_busy));
        check($sformatf("vec%0d.ctrl_addr", idx), 64'(ctrl_addr), 64'(v.e_addr));
        check($sformatf("vec%0d.ctrl_wdata", idx), ctrl_wdata, v.e_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[$];
        logic seen_we;
        logic we_hist[40];
        logic busy_hist[40];
        logic [7:0] addr_hist[40];
        int s1, s2, rec;

        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
        b_rst_n = 1'b0; b_v0 = 1'b0; b_v1 = 1'b0;
        b_a0 = 8'hA0; b_a1 = 8'hA1; b_d0 = DC; b_d1 = DD;

        // rst_n, v0, v1, a0, a1, d0, d1, exp r0, r1, we, busy, addr, data
        // Reset, then a single host write
        vecs.push_back('{0,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h00,DZ});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h00,DZ});
        vecs.push_back('{1,1,0,8'h05,8'h00,D1,DZ, 1,0,0,0,8'h00,DZ});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h05,D1});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,1,1,8'h05,D1});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h05,D1});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h05,D1});
        // Reset again so that last_grant returns to 1, then a continuous tie
        vecs.push_back('{0,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h00,DZ});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 1,0,0,0,8'h00,DZ});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,1,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,1,0,0,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h22,DB});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,1,1,8'h22,DB});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h22,DB});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 1,0,0,0,8'h22,DB});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,1,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,1,0,0,8'h11,DA});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,0,1,8'h22,DB});
        vecs.push_back('{1,1,1,8'h11,8'h22,DA,DB, 0,0,1,1,8'h22,DB});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h22,DB});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h22,DB});
        // Back-pressure: req1 raised during req0's STROBE waits for IDLE
        vecs.push_back('{1,1,0,8'h33,8'h00,DC,DZ, 1,0,0,0,8'h22,DB});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h33,DC});
        vecs.push_back('{1,0,1,8'h00,8'h44,DZ,DD, 0,0,1,1,8'h33,DC});
        vecs.push_back('{1,0,1,8'h00,8'h44,DZ,DD, 0,0,0,1,8'h33,DC});
        vecs.push_back('{1,0,1,8'h00,8'h44,DZ,DD, 0,1,0,0,8'h33,DC});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h44,DD});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,1,1,8'h44,DD});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h44,DD});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h44,DD});
        // req0 raised and dropped while busy: no handshake, no write
        vecs.push_back('{1,0,1,8'h00,8'h66,DZ,DE, 0,1,0,0,8'h44,DD});
        vecs.push_back('{1,1,0,8'h77,8'h00,DF,DZ, 0,0,0,1,8'h66,DE});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,1,1,8'h66,DE});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,1,8'h66,DE});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h66,DE});
        vecs.push_back('{1,0,0,8'h00,8'h00,DZ,DZ, 0,0,0,0,8'h66,DE});

        $display("[TB] vector table: %0d entries", vecs.size());
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkOutput(vecs[i], i);
            tick();
        end

        // Reset asserted in SETUP aborts the write
        req0_valid = 1'b1; req0_addr = 8'h5A; req0_wdata = DF;
        @(negedge clk);
        check("abort.handshake_ready", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        check("abort.in_setup_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy_cleared", 64'(busy), 64'd0);
        check("abort.we_cleared", 64'(ctrl_write_enable), 64'd0);
        check("abort.addr_cleared", 64'(ctrl_addr), 64'd0);
        check("abort.wdata_cleared", ctrl_wdata, 64'd0);
        #1;
        rst_n = 1'b1;
        seen_we = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (ctrl_write_enable) seen_we = 1'b1;
        end
        check("abort.no_strobe", 64'(seen_we), 64'd0);
        tick();
        req0_valid = 1'b1; req0_addr = 8'h5B; req0_wdata = DE;
        @(negedge clk);
        check("after_abort.ready", 64'(req0_ready), 64'd1);
        tick();
        req0_valid = 1'b0;
        @(negedge clk);
        check("after_abort.we_n1", 64'(ctrl_write_enable), 64'd0);
        tick();
        @(negedge clk);
        check("after_abort.we_n2", 64'(ctrl_write_enable), 64'd1);
        check("after_abort.addr", 64'(ctrl_addr), 64'h5B);
        check("after_abort.wdata", ctrl_wdata, DE);
        tick();

        // RECOVER_CYCLES = 3: back-to-back writes on the second instance
        b_rst_n = 1'b1;
        b_v0 = 1'b1;
        b_v1 = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            we_hist[c]   = b_we;
            busy_hist[c] = b_busy;
            addr_hist[c] = b_addr;
        end
        b_v0 = 1'b0;
        b_v1 = 1'b0;
        s1 = -1;
        s2 = -1;
        for (int c = 0; c < 40; c++) begin
            if (we_hist[c]) begin
                if (s1 < 0) s1 = c;
                else if (s2 < 0) s2 = c;
            end
        end
        check("recover.first_strobe_cycle", 64'(s1), 64'd2);
        if (s1 >= 0 && s2 >= 0) begin
            check("recover.strobe_spacing", 64'(s2 - s1), 64'd6);
            rec = 0;
            for (int c = s1 + 1; c < 40; c++) begin
                if (!busy_hist[c]) break;
                if (!we_hist[c]) rec++;
            end
            check("recover.low_cycles", 64'(rec), 64'd3);
            check("recover.first_addr", 64'(addr_hist[s1]), 64'hA0);
            check("recover.second_addr", 64'(addr_hist[s2]), 64'hA1);
        end else begin
            compared++;
            mismatched++;
            $display("[TB] FAIL recover.strobes: got fewer than 2 strobes in 40 cycles, required 2");
        end

`ifdef CMS_CTRL_ARB_STATS_EN
        begin
            logic [31:0] gc1_before;
            tick();
            force dut.grant_count0_q = 32'hFFFF_FFFF;
            tick();
            release dut.grant_count0_q;
            gc1_before = gc1;
            req0_valid = 1'b1; req0_addr = 8'h09; req0_wdata = D1;
            tick();
            req0_valid = 1'b0;
            @(negedge clk);
            check("stats.count0_wrap", 64'(gc0), 64'd0);
            check("stats.count1_kept", 64'(gc1), 64'(gc1_before));
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
